// File: rtl/vid_osd_text_writer.sv
// vid_osd_text_writer
// Host-side character writer for the 64x32 OSD text plane held in GPU RAM.
// Accepts a byte stream, tracks the cursor and writes glyph codes at
// TEXT_BASE + {row, col}. Handles CR, LF, BS, whole-screen clear and the
// end-of-screen action.
// Optional feature macro: OSD_WRITER_SCROLL_EN
//   defined   : newline on the last row scrolls the buffer up one row
//   undefined : newline on the last row wraps to row 0 and blanks it
module vid_osd_text_writer #(
  parameter logic [19:0] TEXT_BASE  = 20'h01000,
  parameter int          RD_LATENCY = 2,
  parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        char_in_valid,
  input  logic [7:0]  char_in_data,
  output logic        char_in_ready,
  input  logic        clear_req,
  output logic        ram_wr_ena,
  output logic [19:0] ram_addr,
  output logic [7:0]  ram_wr_data,
  input  logic [7:0]  ram_rd_data,
  output logic        busy,
  output logic [5:0]  cursor_x,
  output logic [4:0]  cursor_y
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_BLANK = 3'd2;
`ifdef OSD_WRITER_SCROLL_EN
  localparam logic [2:0] ST_SCR_RD   = 3'd3;
  localparam logic [2:0] ST_SCR_WAIT = 3'd4;
  localparam logic [2:0] ST_SCR_WR   = 3'd5;
  // SCR_WAIT lasts RD_LATENCY-1 clocks; the counter is loaded with that minus one
  localparam logic [1:0] WAIT_INIT   = (RD_LATENCY >= 2) ? 2'(RD_LATENCY - 2) : 2'd0;
`endif

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_CR = 8'h0D;

  logic [2:0]  r_state;
  logic [5:0]  r_x;
  logic [4:0]  r_y;
  logic [10:0] r_idx;       // buffer offset walked by CLEAR / BLANK / scroll
  logic        r_wr_ena;
  logic [19:0] r_addr;
  logic [7:0]  r_wr_data;
`ifdef OSD_WRITER_SCROLL_EN
  logic [1:0]  r_wait;
`endif

  logic        w_xfer;
  logic        w_ctrl;
  logic        w_newline;
  logic [10:0] w_pos;
  logic [10:0] w_pos_bs;

  assign char_in_ready = (r_state == ST_IDLE) & ~clear_req;
  assign w_xfer        = char_in_valid & char_in_ready;
  assign w_ctrl        = (char_in_data == CODE_BS) | (char_in_data == CODE_LF) |
                         (char_in_data == CODE_CR);
  // LF, or a printable character landing in the last column
  assign w_newline     = w_xfer & ((char_in_data == CODE_LF) | (~w_ctrl & (r_x == 6'd63)));
  assign w_pos         = {r_y, r_x};
  assign w_pos_bs      = {r_y, r_x - 6'd1};

  assign busy        = (r_state != ST_IDLE);
  assign ram_wr_ena  = r_wr_ena;
  assign ram_addr    = r_addr;
  assign ram_wr_data = r_wr_data;
  assign cursor_x    = r_x;
  assign cursor_y    = r_y;

`ifndef OSD_WRITER_SCROLL_EN
  // Read port and latency only matter when scrolling is built in
  logic w_unused_ok;
  assign w_unused_ok = (^ram_rd_data) ^ (RD_LATENCY > 0);
`endif

  // 11-bit offset into the text window; never leaves TEXT_BASE..TEXT_BASE+2047
  function automatic logic [19:0] f_addr(input logic [10:0] off);
    return TEXT_BASE + {9'd0, off};
  endfunction

  // Cursor tracking, FSM sequencing and the registered RAM port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_idx     <= '0;
      r_wr_ena  <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
`ifdef OSD_WRITER_SCROLL_EN
      r_wait    <= '0;
`endif
    end else begin
      r_wr_ena <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clear_req) begin
            // clear takes priority; a same-cycle character is left for later
            r_state <= ST_CLEAR;
            r_idx   <= '0;
          end else if (w_xfer) begin
            if ((char_in_data == CODE_CR) || (char_in_data == CODE_LF)) begin
              r_x <= '0;
            end else if (char_in_data == CODE_BS) begin
              if (r_x != 6'd0) begin
                r_x       <= r_x - 6'd1;
                r_wr_ena  <= 1'b1;
                r_addr    <= f_addr(w_pos_bs);
                r_wr_data <= FILL_CHAR;
              end
            end else begin
              r_wr_ena  <= 1'b1;
              r_addr    <= f_addr(w_pos);
              r_wr_data <= char_in_data;
              r_x       <= r_x + 6'd1;   // column 63 wraps to 0
            end
            if (w_newline) begin
              if (r_y != 5'd31) begin
                r_y <= r_y + 5'd1;
              end else begin
`ifdef OSD_WRITER_SCROLL_EN
                r_state <= ST_SCR_RD;
                r_idx   <= 11'd64;
`else
                r_y     <= '0;
                r_state <= ST_BLANK;
                r_idx   <= '0;
`endif
              end
            end
          end
        end
        ST_CLEAR: begin
          r_wr_ena  <= 1'b1;
          r_addr    <= f_addr(r_idx);
          r_wr_data <= FILL_CHAR;
          r_idx     <= r_idx + 11'd1;
          if (r_idx == 11'd2047) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
          end
        end
        ST_BLANK: begin
          r_wr_ena  <= 1'b1;
          r_addr    <= f_addr(r_idx);
          r_wr_data <= FILL_CHAR;
          r_idx     <= r_idx + 11'd1;
          if (r_idx[5:0] == 6'd63) begin
            r_state <= ST_IDLE;
          end
        end
`ifdef OSD_WRITER_SCROLL_EN
        ST_SCR_RD: begin
          r_addr <= f_addr(r_idx);
          if (RD_LATENCY <= 1) begin
            r_state <= ST_SCR_WR;
          end else begin
            r_wait  <= WAIT_INIT;
            r_state <= ST_SCR_WAIT;
          end
        end
        ST_SCR_WAIT: begin
          if (r_wait == 2'd0) begin
            r_state <= ST_SCR_WR;
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        ST_SCR_WR: begin
          // read data for offset i lands one row up
          r_wr_ena  <= 1'b1;
          r_addr    <= f_addr(r_idx - 11'd64);
          r_wr_data <= ram_rd_data;
          r_idx     <= r_idx + 11'd1;
          if (r_idx == 11'd2047) begin
            r_state <= ST_BLANK;
            r_idx   <= 11'd1984;
          end else begin
            r_state <= ST_SCR_RD;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vid_osd_text_writer.sv
// Testbench for vid_osd_text_writer: directed steps, write scoreboard and a
// byte-wide RAM model with one read register stage (RD_LATENCY = 2).
module tb_vid_osd_text_writer;

  localparam logic [19:0] BASE = 20'h01000;
  localparam logic [7:0]  FILL = 8'h20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        char_in_valid;
  logic [7:0]  char_in_data;
  logic        char_in_ready;
  logic        clear_req;
  logic        ram_wr_ena;
  logic [19:0] ram_addr;
  logic [7:0]  ram_wr_data;
  logic [7:0]  ram_rd_data;
  logic        busy;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;

  vid_osd_text_writer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .char_in_valid(char_in_valid),
    .char_in_data (char_in_data),
    .char_in_ready(char_in_ready),
    .clear_req    (clear_req),
    .ram_wr_ena   (ram_wr_ena),
    .ram_addr     (ram_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_data  (ram_rd_data),
    .busy         (busy),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [27:0] exp_q[$];
  logic [7:0]  mem [0:2047];
  logic [7:0]  rd_q;
  logic        fill_req = 1'b0;
  logic [10:0] ram_off;

  assign ram_off     = 11'(ram_addr - BASE);
  assign ram_rd_data = rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [19:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    char_in_valid = 1'b1;
    char_in_data  = c;
    tick();
    char_in_valid = 1'b0;
  endtask

  // RAM model: synchronous write, one registered read stage, backdoor fill
  always @(posedge clk) begin
    if (ram_wr_ena) mem[ram_off] <= ram_wr_data;
    rd_q <= mem[ram_off];
    if (fill_req) begin
      for (int i = 0; i < 2048; i++) mem[11'(i)] <= 8'(i >> 6);
    end
  end

  // Scoreboard: every RAM write must match the next expected write
  always @(negedge clk) begin
    if (reset_n && ram_wr_ena) begin
      if (exp_q.size() == 0)
        chk("unexpected_write", {4'd0, ram_addr, ram_wr_data}, 32'hFFFF_FFFF);
      else
        chk("write", {4'd0, ram_addr, ram_wr_data}, {4'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int         n;
    int         exp_busy;
    int         bad;
    logic [7:0] e;

    reset_n       = 1'b0;
    char_in_valid = 1'b0;
    char_in_data  = 8'h00;
    clear_req     = 1'b0;
    tick();
    tick();
    chk("rst_wr_ena", 32'(ram_wr_ena), 32'd0);
    chk("rst_addr",   32'(ram_addr),   32'd0);
    chk("rst_data",   32'(ram_wr_data), 32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_cursor", {21'd0, cursor_y, cursor_x}, 32'd0);
    chk("rst_ready",  32'(char_in_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // 1: 'A','B' back to back
    char_in_valid = 1'b1;
    char_in_data  = 8'h41;
    push(20'h01000, 8'h41);
    tick();
    chk("t1_ready0", 32'(char_in_ready), 32'd1);
    chk("t1_wr0", {11'd0, ram_wr_ena, ram_addr}, {11'd0, 1'b1, 20'h01000});
    char_in_data = 8'h42;
    push(20'h01001, 8'h42);
    tick();
    chk("t1_ready1", 32'(char_in_ready), 32'd1);
    chk("t1_wr1", {11'd0, ram_wr_ena, ram_addr}, {11'd0, 1'b1, 20'h01001});
    chk("t1_cursor", {21'd0, cursor_y, cursor_x}, {21'd0, 5'd0, 6'd2});
    char_in_valid = 1'b0;
    tick();
    chk("t1_idle_nowr", 32'(ram_wr_ena), 32'd0);

    // 2: full row of 'X', then CR / LF
    send(8'h0D);
    chk("t2_cr_nowr", 32'(ram_wr_ena), 32'd0);
    for (int i = 0; i < 64; i++) begin
      push(BASE + 20'(i), 8'h58);
      send(8'h58);
    end
    chk("t2_last_wr", {11'd0, ram_wr_ena, ram_addr}, {11'd0, 1'b1, 20'h0103F});
    chk("t2_cursor_row1", {21'd0, cursor_y, cursor_x}, {21'd0, 5'd1, 6'd0});
    send(8'h0D);
    chk("t2_cr2_nowr", 32'(ram_wr_ena), 32'd0);
    send(8'h0A);
    chk("t2_lf_nowr", 32'(ram_wr_ena), 32'd0);
    chk("t2_cursor_row2", {21'd0, cursor_y, cursor_x}, {21'd0, 5'd2, 6'd0});

    // 3: backspace at (5,3) and at (0,3)
    send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      push(BASE + 20'(192 + i), 8'h61);
      send(8'h61);
    end
    chk("t3_cursor_53", {21'd0, cursor_y, cursor_x}, {21'd0, 5'd3, 6'd5});
    push(20'h010C4, FILL);
    send(8'h08);
    chk("t3_bs_wr", {11'd0, ram_wr_ena, ram_addr}, {11'd0, 1'b1, 20'h010C4});
    chk("t3_cursor_43", {21'd0, cursor_y, cursor_x}, {21'd0, 5'd3, 6'd4});
    send(8'h0D);
    send(8'h08);
    chk("t3_bs_col0_nowr", 32'(ram_wr_ena), 32'd0);
    chk("t3_cursor_03", {21'd0, cursor_y, cursor_x}, {21'd0, 5'd3, 6'd0});

    // 4: clear with a same-cycle character
    char_in_valid = 1'b1;
    char_in_data  = 8'h51;
    clear_req     = 1'b1;
    #1;
    chk("t4_ready_clr", 32'(char_in_ready), 32'd0);
    for (int i = 0; i < 2048; i++) push(BASE + 20'(i), FILL);
    tick();
    clear_req = 1'b0;
    n = 0;
    while (busy && n < 4000) begin
      n++;
      if (n == 100) chk("t4_ready_busy", 32'(char_in_ready), 32'd0);
      tick();
    end
    chk("t4_busy_clocks", n, 32'd2048);
    chk("t4_cursor_home", {21'd0, cursor_y, cursor_x}, 32'd0);
    push(BASE, 8'h51);
    tick();
    char_in_valid = 1'b0;
    chk("t4_char_after", {3'd0, ram_wr_ena, ram_addr, ram_wr_data}, {3'd0, 1'b1, BASE, 8'h51});
    chk("t4_cursor_10", {21'd0, cursor_y, cursor_x}, {21'd0, 5'd0, 6'd1});

    // 5: end-of-screen action from (63,31)
    send(8'h0D);
    for (int i = 0; i < 31; i++) send(8'h0A);
    chk("t5_cursor_031", {21'd0, cursor_y, cursor_x}, {21'd0, 5'd31, 6'd0});
    for (int c = 0; c < 63; c++) begin
      push(BASE + 20'(1984 + c), 8'h4D);
      send(8'h4D);
    end
    chk("t5_cursor_6331", {21'd0, cursor_y, cursor_x}, {21'd0, 5'd31, 6'd63});
    tick();
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    push(20'h017FF, 8'h5A);
`ifdef OSD_WRITER_SCROLL_EN
    for (int i = 64; i < 2048; i++) push(BASE + 20'(i - 64), (i == 2047) ? 8'h5A : 8'(i >> 6));
    for (int c = 0; c < 64; c++) push(BASE + 20'(1984 + c), FILL);
    exp_busy = 1984 * 3 + 64;
`else
    for (int c = 0; c < 64; c++) push(BASE + 20'(c), FILL);
    exp_busy = 64;
`endif
    send(8'h5A);
    n = 0;
    while (busy && n < 10000) begin
      n++;
      tick();
    end
    chk("t5_busy_clocks", n, exp_busy);
    tick();
    for (int r = 0; r < 32; r++) begin
      bad = 0;
      for (int c = 0; c < 64; c++) begin
`ifdef OSD_WRITER_SCROLL_EN
        if (r <= 29)      e = 8'(r + 1);
        else if (r == 30) e = (c == 63) ? 8'h5A : 8'd31;
        else              e = FILL;
`else
        if (r == 0)       e = FILL;
        else if (r <= 30) e = 8'(r);
        else              e = (c == 63) ? 8'h5A : 8'd31;
`endif
        if (mem[11'(r * 64 + c)] !== e) bad++;
      end
      chk($sformatf("t5_row%0d_bad_bytes", r), bad, 32'd0);
    end
`ifdef OSD_WRITER_SCROLL_EN
    chk("t5_cursor_end", {21'd0, cursor_y, cursor_x}, {21'd0, 5'd31, 6'd0});
`else
    chk("t5_cursor_end", {21'd0, cursor_y, cursor_x}, 32'd0);
`endif

    // 6: reset in the middle of a clear
    for (int i = 0; i < 10; i++) push(BASE + 20'(i), FILL);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_wr_ena", 32'(ram_wr_ena), 32'd0);
    chk("t6_addr",   32'(ram_addr),   32'd0);
    chk("t6_data",   32'(ram_wr_data), 32'd0);
    chk("t6_busy",   32'(busy),       32'd0);
    chk("t6_cursor", {21'd0, cursor_y, cursor_x}, 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("t6_ready_after", 32'(char_in_ready), 32'd1);
    chk("t6_busy_after",  32'(busy), 32'd0);
    tick();
    chk("t6_no_write_after", 32'(ram_wr_ena), 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
